cordic_add_subt_fx: RTL and testbench

- Fixed-point add/subtract responder on the CORDIC datapath; the far end of the beg_add_subt / ready_add_subt / ack_add_subt handshake issued by the CORDIC control FSM.
- Computes data_a ± (data_b >>> shift_amt) in two's complement. Shifting is serial, one bit per cycle.
- Holds the result and ready_add_subt until the FSM acknowledges.

---
 rtl/cordic_add_subt_pkg.sv | 18 +
 rtl/add_subt_fx_core.sv | 45 ++++
 rtl/cordic_add_subt_fx.sv | 114 +++++++++++
 tb/tb_cordic_add_subt_fx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_add_subt_pkg.sv
// Shared state encoding and op codes for the CORDIC add/subtract responder.
`default_nettype none

package cordic_add_subt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/add_subt_fx_core.sv
// Combinational two's-complement add/subtract with signed overflow detection.
// Saturates on overflow when CORDIC_ADD_SUBT_SATURATION_EN is defined, otherwise wraps.
`default_nettype none

module add_subt_fx_core
  import cordic_add_subt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_op,
  output logic [W-1:0] o_result,
  output logic         o_ovf
);

  logic [W:0] w_a_ext;
  logic [W:0] w_b_ext;
  logic [W:0] w_sum;

  assign w_a_ext = {i_a[W-1], i_a};
  assign w_b_ext = {i_b[W-1], i_b};

  // One guard bit makes the sum exact, so overflow is simply the top two bits disagreeing.
  always_comb begin
    w_sum = '0;
    case (i_op)
      OP_ADD:  w_sum = w_a_ext + w_b_ext;
      OP_SUB:  w_sum = w_a_ext - w_b_ext;
      default: w_sum = w_a_ext + w_b_ext;
    endcase
  end

  assign o_ovf = w_sum[W] ^ w_sum[W-1];

`ifdef CORDIC_ADD_SUBT_SATURATION_EN
  assign o_result = !o_ovf  ? w_sum[W-1:0] :
                    w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
  assign o_result = w_sum[W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/cordic_add_subt_fx.sv
// CORDIC add/subtract responder: computes data_a +/- (data_b >>> shift_amt), one shift bit per cycle.
// Optional saturation on overflow: define CORDIC_ADD_SUBT_SATURATION_EN.
`default_nettype none

module cordic_add_subt_fx
  import cordic_add_subt_pkg::*;
#(
  parameter int W   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           beg_add_subt,
  input  logic           ack_add_subt,
  input  logic           op_add_subt,
  input  logic [SHW-1:0] shift_amt,
  input  logic [W-1:0]   data_a,
  input  logic [W-1:0]   data_b,
  output logic           ready_add_subt,
  output logic           busy,
  output logic [W-1:0]   result,
  output logic           overflow_flag
);

  localparam logic [SHW-1:0] c_MAX_CNT = SHW'(W - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_op;
  logic [SHW-1:0] r_cnt;
  logic [SHW-1:0] w_cnt_init;
  logic [W-1:0]   r_result;
  logic           r_ovf;
  logic           r_ready;
  logic           r_busy;
  logic [W-1:0]   w_core_result;
  logic           w_core_ovf;

  // Shifting further than W-1 gives the same sign-filled value, so the count is clamped.
  assign w_cnt_init = (int'(shift_amt) > W - 1) ? c_MAX_CNT : shift_amt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (beg_add_subt)    w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == '0)     w_state_nxt = ADD;
      ADD:                          w_state_nxt = DONE;
      DONE:    if (ack_add_subt)    w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == DONE);
      r_busy  <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (beg_add_subt) begin
            r_a   <= data_a;
            r_b   <= data_b;
            r_op  <= op_add_subt;
            r_cnt <= w_cnt_init;
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_b   <= {r_b[W-1], r_b[W-1:1]};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ADD: begin
          r_result <= w_core_result;
          r_ovf    <= w_core_ovf;
        end
        default: ;
      endcase
    end
  end

  add_subt_fx_core #(
    .W (W)
  ) u_core (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_core_result),
    .o_ovf    (w_core_ovf)
  );

  assign ready_add_subt = r_ready;
  assign busy           = r_busy;
  assign result         = r_result;
  assign overflow_flag  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cordic_add_subt_fx.sv
// Scoreboard bench for cordic_add_subt_fx: expectations queued at issue, popped when ready rises.
`default_nettype none

module tb_cordic_add_subt_fx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        beg_add_subt = 1'b0;
  logic        ack_add_subt = 1'b0;
  logic        op_add_subt = 1'b0;
  logic [4:0]  shift_amt = '0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        ready_add_subt;
  logic        busy;
  logic [31:0] result;
  logic        overflow_flag;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  cordic_add_subt_fx #(.W(32), .SHW(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .beg_add_subt   (beg_add_subt),
    .ack_add_subt   (ack_add_subt),
    .op_add_subt    (op_add_subt),
    .shift_amt      (shift_amt),
    .data_a         (data_a),
    .data_b         (data_b),
    .ready_add_subt (ready_add_subt),
    .busy           (busy),
    .result         (result),
    .overflow_flag  (overflow_flag)
  );

  // Reference: exact signed arithmetic in 64 bits, overflow by range check.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic op, input int sh);
    longint sa;
    longint sb;
    longint r;
    logic   ov;
    logic [31:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b)) >>> ((sh > 31) ? 31 : sh);
    r  = op ? (sa - sb) : (sa + sb);
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    res = r[31:0];
`ifdef CORDIC_ADD_SUBT_SATURATION_EN
    if (ov) res = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {ov, res};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic op, input int sh);
    exp_t e;
    logic [32:0] m;
    m = model(a, b, op, sh);
    e.res = m[31:0];
    e.ovf = m[32];
    e.lat = ((sh > 31) ? 31 : sh) + 2;
    data_a = a; data_b = b; op_add_subt = op; shift_amt = 5'(sh);
    beg_add_subt = 1'b1;
    step();
    beg_add_subt = 1'b0;
    sb_q.push_back(e);
    // Operands are free to change once captured.
    data_a = $urandom; data_b = $urandom; op_add_subt = ~op; shift_amt = 5'($urandom);
  endtask

  // Counts edges after the beg edge until ready; bounded.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (ready_add_subt !== 1'b1 && edges < 200) begin
      step();
      edges++;
    end
  endtask

  task automatic do_ack();
    ack_add_subt = 1'b1;
    step();
    ack_add_subt = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_chk++; if ({ready_add_subt, busy, overflow_flag} !== 3'b000 || result !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs: got rdy=%b busy=%b ovf=%b res=%h expected all 0",
                        ready_add_subt, busy, overflow_flag, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    exp_t e; int n;
    start_op(32'h10, 32'h20, 1'b0, 0);
    n_chk++; if (busy !== 1'b1 || ready_add_subt !== 1'b0) begin
      n_err++; $display("FAIL add_busy_edge0: got busy=%b rdy=%b expected 1 0", busy, ready_add_subt);
    end
    wait_ready(n);
    e = sb_q.pop_front();
    n_chk++; if (n !== e.lat) begin n_err++; $display("FAIL add_latency: got %0d expected %0d", n, e.lat); end
    n_chk++; if (result !== 32'h30 || result !== e.res) begin
      n_err++; $display("FAIL add_result: got %h expected %h", result, e.res);
    end
    n_chk++; if (overflow_flag !== e.ovf || busy !== 1'b1) begin
      n_err++; $display("FAIL add_ovf_busy: got ovf=%b busy=%b expected %b 1", overflow_flag, busy, e.ovf);
    end
    do_ack();
    n_chk++; if (ready_add_subt !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL add_ack: got rdy=%b busy=%b expected 0 0", ready_add_subt, busy);
    end
  endtask

  task automatic test_sub_shift();
    exp_t e; int n;
    start_op(32'h100, 32'hFFFF_FF00, 1'b1, 4);
    wait_ready(n);
    e = sb_q.pop_front();
    n_chk++; if (n !== e.lat) begin n_err++; $display("FAIL sub_latency: got %0d expected %0d", n, e.lat); end
    n_chk++; if (result !== 32'h110 || overflow_flag !== e.ovf) begin
      n_err++; $display("FAIL sub_result: got %h ovf=%b expected %h ovf=%b", result, overflow_flag, e.res, e.ovf);
    end
    do_ack();
  endtask

  task automatic test_overflow();
    exp_t e; int n;
    start_op(32'h7FFF_FFFF, 32'h1, 1'b0, 0);
    wait_ready(n);
    e = sb_q.pop_front();
    n_chk++; if (result !== e.res || overflow_flag !== 1'b1) begin
      n_err++; $display("FAIL ovf_pos: got %h ovf=%b expected %h ovf=1", result, overflow_flag, e.res);
    end
    do_ack();
    start_op(32'h8000_0000, 32'h1, 1'b1, 0);
    wait_ready(n);
    e = sb_q.pop_front();
    n_chk++; if (result !== e.res || overflow_flag !== 1'b1) begin
      n_err++; $display("FAIL ovf_neg: got %h ovf=%b expected %h ovf=1", result, overflow_flag, e.res);
    end
    do_ack();
    // Flag and result persist in IDLE.
    step();
    n_chk++; if (result !== e.res || overflow_flag !== 1'b1) begin
      n_err++; $display("FAIL ovf_hold_idle: got %h ovf=%b expected %h ovf=1", result, overflow_flag, e.res);
    end
  endtask

  task automatic test_hold_ignore();
    exp_t e; int n;
    start_op(32'h5, 32'h400, 1'b0, 8);
    step();
    data_a = 32'hDEAD_BEEF; data_b = 32'h1234_5678; beg_add_subt = 1'b1;
    step();
    beg_add_subt = 1'b0;
    wait_ready(n);
    e = sb_q.pop_front();
    n_chk++; if (n !== e.lat - 2 || result !== 32'h9) begin
      n_err++; $display("FAIL hold_first: got edges=%0d res=%h expected %0d %h", n, result, e.lat - 2, e.res);
    end
    for (int i = 0; i < 10; i++) begin
      beg_add_subt = (i == 3);
      step();
      n_chk++; if (ready_add_subt !== 1'b1 || result !== e.res) begin
        n_err++; $display("FAIL hold_stable: cycle %0d got rdy=%b res=%h expected 1 %h", i, ready_add_subt, result, e.res);
      end
    end
    beg_add_subt = 1'b0;
    do_ack();
    step(); step();
    n_chk++; if (busy !== 1'b0 || ready_add_subt !== 1'b0) begin
      n_err++; $display("FAIL hold_no_queue: got busy=%b rdy=%b expected 0 0", busy, ready_add_subt);
    end
  endtask

  task automatic test_beg_ack_together();
    exp_t e; int n;
    start_op(32'h3, 32'h4, 1'b1, 0);
    wait_ready(n);
    e = sb_q.pop_front();
    n_chk++; if (result !== e.res) begin n_err++; $display("FAIL begack_result: got %h expected %h", result, e.res); end
    beg_add_subt = 1'b1; ack_add_subt = 1'b1;
    step();
    beg_add_subt = 1'b0; ack_add_subt = 1'b0;
    n_chk++; if (busy !== 1'b0 || ready_add_subt !== 1'b0) begin
      n_err++; $display("FAIL begack_idle: got busy=%b rdy=%b expected 0 0", busy, ready_add_subt);
    end
    repeat (3) step();
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL begack_no_start: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_op();
    exp_t e; int n;
    start_op(32'h1234, 32'h5678, 1'b0, 20);
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({ready_add_subt, busy, overflow_flag} !== 3'b000 || result !== 32'h0) begin
      n_err++; $display("FAIL reset_mid: got rdy=%b busy=%b ovf=%b res=%h expected all 0",
                        ready_add_subt, busy, overflow_flag, result);
    end
    sb_q.delete();
    step();
    reset = 1'b0;
    start_op(32'h1, 32'h1, 1'b0, 0);
    wait_ready(n);
    e = sb_q.pop_front();
    n_chk++; if (n !== e.lat || result !== 32'h2) begin
      n_err++; $display("FAIL reset_after: got edges=%0d res=%h expected %0d 00000002", n, result, e.lat);
    end
    do_ack();
  endtask

  task automatic test_max_shift();
    exp_t e; int n;
    start_op(32'h0, 32'h8000_0000, 1'b0, 31);
    wait_ready(n);
    e = sb_q.pop_front();
    n_chk++; if (n !== 33) begin n_err++; $display("FAIL maxshift_latency: got %0d expected 33", n); end
    n_chk++; if (result !== 32'hFFFF_FFFF || overflow_flag !== e.ovf) begin
      n_err++; $display("FAIL maxshift_result: got %h ovf=%b expected ffffffff ovf=%b", result, overflow_flag, e.ovf);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    exp_t e; int n;
    for (int i = 0; i < 8; i++) begin
      start_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
      wait_ready(n);
      e = sb_q.pop_front();
      n_chk++; if (n !== e.lat || result !== e.res || overflow_flag !== e.ovf) begin
        n_err++; $display("FAIL b2b_%0d: got edges=%0d res=%h ovf=%b expected %0d %h %b",
                          i, n, result, overflow_flag, e.lat, e.res, e.ovf);
      end
      do_ack();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_shift();
    test_overflow();
    test_hold_ignore();
    test_beg_ack_together();
    test_reset_mid_op();
    test_max_shift();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
